// File: rtl/ccis_c1tx_arb_buffer_pkg.sv
// Shared types and helpers for the CCI-S channel-1 Tx arbitration buffer.
package ccis_tx_buf_pkg;

  localparam int CCIS_TX_BUF_CNT_W   = 32;
  localparam int CCIS_TX_BUF_NUM_SRC = 4;

  // Index width for n sources; never narrower than one bit.
  function automatic int ccis_tx_buf_clog2(input int n);
    int w;
    w = 1;
    for (int k = 0; k < 8; k++) begin
      if ((32'sd1 <<< w) < n) w = w + 1;
      else                    w = w;
    end
    return w;
  endfunction

  typedef logic [ccis_tx_buf_clog2(CCIS_TX_BUF_NUM_SRC)-1:0] t_ccis_tx_buf_idx;

  typedef struct packed {
    logic [5:0]  rsvd2;
    logic [3:0]  req_type;
    logic [5:0]  rsvd1;
    logic [31:0] address;
    logic [1:0]  rsvd0;
    logic [15:0] mdata;
  } t_ccis_c1_ReqMemHdr;

  typedef struct packed {
    t_ccis_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               wrValid;
    logic               intrValid;
  } t_if_ccis_c1_Tx;

  // A c1 Tx beat carries a request when either valid is set.
  function automatic logic ccis_c1Tx_isValid(input t_if_ccis_c1_Tx tx);
    return tx.wrValid || tx.intrValid;
  endfunction

  // Returns the request with every reserved header field forced to zero.
  function automatic t_if_ccis_c1_Tx ccis_c1Tx_clearRsvd(input t_if_ccis_c1_Tx tx);
    t_if_ccis_c1_Tx t;
    t           = tx;
    t.hdr.rsvd2 = 6'd0;
    t.hdr.rsvd1 = 6'd0;
    t.hdr.rsvd0 = 2'd0;
    return t;
  endfunction

endpackage

// File: rtl/ccis_c1tx_arb_buffer_if.sv
// Bus bundle between AFU sources, the arbitration buffer and the CCI-S edge.
interface ccis_c1tx_arb_buffer_if #(parameter int NUM_SRC = 4);
  import ccis_tx_buf_pkg::*;

  t_if_ccis_c1_Tx [NUM_SRC-1:0]                          src_c1Tx;
  logic           [NUM_SRC-1:0]                          src_c1TxAlmFull;
  t_if_ccis_c1_Tx                                        c1Tx;
  logic                                                  c1TxAlmFull;
  logic           [NUM_SRC-1:0]                          overflow_err;
  logic           [NUM_SRC-1:0][CCIS_TX_BUF_CNT_W-1:0]   stall_cnt;

  modport slave  (input  src_c1Tx, c1TxAlmFull,
                  output src_c1TxAlmFull, c1Tx, overflow_err, stall_cnt);
  modport master (output src_c1Tx, c1TxAlmFull,
                  input  src_c1TxAlmFull, c1Tx, overflow_err, stall_cnt);
endinterface

// File: rtl/ccis_c1tx_arb_buffer_fifo.sv
// Single-source request FIFO; a push into a full FIFO is accepted only when
// the same cycle pops, otherwise it is silently discarded (caller flags it).
module ccis_tx_buf_fifo
  import ccis_tx_buf_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int ALM_FULL_SLACK = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enq_i,
  input  t_if_ccis_c1_Tx         enq_data_i,
  input  logic                   deq_i,
  output t_if_ccis_c1_Tx         deq_data_o,
  output logic [$clog2(DEPTH):0] occ_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   alm_full_o
);
  localparam int AW = $clog2(DEPTH);

  t_if_ccis_c1_Tx mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    occ_q, occ_d;
  logic           alm_q, alm_d;
  logic           push_s, pop_s;

  // Next-state pointers, occupancy and almost-full.
  always_comb begin
    pop_s    = deq_i && (occ_q != (AW+1)'(0));
    push_s   = enq_i && ((occ_q != (AW+1)'(DEPTH)) || pop_s);
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    alm_d = (occ_d >= (AW+1)'(DEPTH - ALM_FULL_SLACK));
  end

  // Control state; almost-full reads 1 while in reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      alm_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      alm_q    <= alm_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign deq_data_o = mem_q[rd_ptr_q];
  assign occ_o      = occ_q;
  assign full_o     = (occ_q == (AW+1)'(DEPTH));
  assign empty_o    = (occ_q == (AW+1)'(0));
  assign alm_full_o = alm_q;

endmodule

// File: rtl/ccis_c1tx_arb_buffer.sv
// Per-source c1 Tx FIFOs merged round-robin onto one registered c1Tx port.
// Define CCIS_TX_BUF_STATS_EN to build the per-source starvation counters.
module ccis_c1tx_arb_buffer
  import ccis_tx_buf_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DEPTH          = 8,
  parameter int ALM_FULL_SLACK = 2
) (
  input logic                    clk,
  input logic                    reset,
  ccis_c1tx_arb_buffer_if.slave  bus
);
  localparam int IW = ccis_tx_buf_clog2(NUM_SRC);

  logic           [NUM_SRC-1:0]                 enq_s, deq_s, empty_s, full_s, alm_s;
  t_if_ccis_c1_Tx [NUM_SRC-1:0]                 enq_data_s, deq_data_s;
  // Occupancy is brought out for debug visibility; arbitration needs only empty/full.
  logic           [NUM_SRC-1:0][$clog2(DEPTH):0] occ_dbg_unused_s;

  logic [IW-1:0]        rr_ptr_q, rr_ptr_d, grant_idx_s;
  logic                 grant_vld_s;
  t_if_ccis_c1_Tx       c1Tx_q, c1Tx_d;
  logic [NUM_SRC-1:0]   overflow_q, overflow_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign enq_s[i]      = ccis_c1Tx_isValid(bus.src_c1Tx[i]);
    assign enq_data_s[i] = ccis_c1Tx_clearRsvd(bus.src_c1Tx[i]);
    assign deq_s[i]      = grant_vld_s && (grant_idx_s == IW'(i));

    ccis_tx_buf_fifo #(.DEPTH(DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)) u_fifo (
      .clk_i      (clk),
      .reset_i    (reset),
      .enq_i      (enq_s[i]),
      .enq_data_i (enq_data_s[i]),
      .deq_i      (deq_s[i]),
      .deq_data_o (deq_data_s[i]),
      .occ_o      (occ_dbg_unused_s[i]),
      .full_o     (full_s[i]),
      .empty_o    (empty_s[i]),
      .alm_full_o (alm_s[i])
    );
  end

  // Round-robin grant: scan from farthest to nearest after rr_ptr so the nearest wins.
  always_comb begin
    logic [IW-1:0] cand;
    cand        = '0;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    if (!bus.c1TxAlmFull) begin
      for (int k = NUM_SRC; k >= 1; k--) begin
        cand = IW'((int'(rr_ptr_q) + k) % NUM_SRC);
        if (!empty_s[cand]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = cand;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      grant_vld_s = 1'b0;
    end
  end

  // Next output beat, pointer update and sticky drop flags.
  always_comb begin
    c1Tx_d     = grant_vld_s ? deq_data_s[grant_idx_s] : '0;
    rr_ptr_d   = grant_vld_s ? grant_idx_s : rr_ptr_q;
    overflow_d = overflow_q | (enq_s & full_s & ~deq_s);
  end

  // Registered downstream request, arbiter pointer and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      c1Tx_q     <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= '0;
    end else begin
      c1Tx_q     <= c1Tx_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.c1Tx            = c1Tx_q;
  assign bus.src_c1TxAlmFull = alm_s;
  assign bus.overflow_err    = overflow_q;

`ifdef CCIS_TX_BUF_STATS_EN
  logic [NUM_SRC-1:0][CCIS_TX_BUF_CNT_W-1:0] stall_q, stall_d;

  // Count cycles a source holds data but is not served, saturating at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!empty_s[i] && !deq_s[i] && (stall_q[i] != {CCIS_TX_BUF_CNT_W{1'b1}})) begin
        stall_d[i] = stall_q[i] + CCIS_TX_BUF_CNT_W'(1);
      end else begin
        stall_d[i] = stall_q[i];
      end
    end
  end

  // Starvation counter registers.
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ccis_c1tx_arb_buffer.sv
// Self-checking bench: directed table, hand sequences and random traffic
// compared against a queue-based reference model.
module tb_ccis_c1tx_arb_buffer;
  import ccis_tx_buf_pkg::*;

  localparam int NS    = 4;
  localparam int DEPTH = 8;
  localparam int SLACK = 2;
  localparam int W     = $bits(t_if_ccis_c1_Tx);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ccis_c1tx_arb_buffer_if #(.NUM_SRC(NS)) bus();

  ccis_c1tx_arb_buffer #(.NUM_SRC(NS), .DEPTH(DEPTH), .ALM_FULL_SLACK(SLACK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  t_if_ccis_c1_Tx mq [NS][$];
  int             m_rr;
  logic [NS-1:0]  m_ovf, m_alm;
  longint         m_stall [NS];
  t_if_ccis_c1_Tx m_out;

  t_if_ccis_c1_Tx stim [NS];
  int             dut_emit [NS];
  int             tag = 0;

  typedef struct {
    bit       rst;
    bit [3:0] req;
    bit       blk;
    bit       exp_vld;
    int       exp_src;
    bit [3:0] exp_alm;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic t_if_ccis_c1_Tx mk_req(input int src, input int t, input bit intr);
    t_if_ccis_c1_Tx r;
    r.hdr.rsvd2    = 6'($urandom());
    r.hdr.req_type = 4'(src);
    r.hdr.rsvd1    = 6'($urandom());
    r.hdr.address  = {4'(src), 28'(t)};
    r.hdr.rsvd0    = 2'($urandom());
    r.hdr.mdata    = 16'(t);
    for (int k = 0; k < 16; k++) r.data[k*32 +: 32] = $urandom();
    r.wrValid   = !intr;
    r.intrValid = intr;
    return r;
  endfunction

  function automatic t_if_ccis_c1_Tx expect_stored(input t_if_ccis_c1_Tx r);
    t_if_ccis_c1_Tx e;
    e = r;
    e.hdr.rsvd2 = '0;
    e.hdr.rsvd1 = '0;
    e.hdr.rsvd0 = '0;
    return e;
  endfunction

  // One clock: drive stim, advance model, compare every output.
  task automatic cycle(input bit blk, input bit rst);
    int g;
    for (int s = 0; s < NS; s++) bus.src_c1Tx[s] = stim[s];
    bus.c1TxAlmFull = blk;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        mq[s].delete();
        m_stall[s] = 0;
      end
      m_rr  = 0;
      m_ovf = '0;
      m_alm = '1;
      m_out = '0;
    end else begin
      g = -1;
      if (!blk) begin
        for (int k = 1; k <= NS; k++) begin
          if (g < 0 && mq[(m_rr + k) % NS].size() > 0) g = (m_rr + k) % NS;
        end
      end
      for (int s = 0; s < NS; s++)
        if (mq[s].size() > 0 && s != g && m_stall[s] < 64'hFFFF_FFFF) m_stall[s]++;
      if (g >= 0) begin
        m_out = mq[g].pop_front();
        m_rr  = g;
      end else begin
        m_out = '0;
      end
      for (int s = 0; s < NS; s++) begin
        if (stim[s].wrValid || stim[s].intrValid) begin
          if (mq[s].size() < DEPTH) mq[s].push_back(expect_stored(stim[s]));
          else                      m_ovf[s] = 1'b1;
        end
      end
      for (int s = 0; s < NS; s++) m_alm[s] = (mq[s].size() >= DEPTH - SLACK);
    end
    #1;
    chk("c1Tx_valids", W'({bus.c1Tx.wrValid, bus.c1Tx.intrValid}),
        W'({m_out.wrValid, m_out.intrValid}));
    if (m_out.wrValid || m_out.intrValid) chk("c1Tx_beat", bus.c1Tx, m_out);
    chk("src_c1TxAlmFull", W'(bus.src_c1TxAlmFull), W'(m_alm));
    chk("overflow_err", W'(bus.overflow_err), W'(m_ovf));
`ifdef CCIS_TX_BUF_STATS_EN
    for (int s = 0; s < NS; s++) chk("stall_cnt", W'(bus.stall_cnt[s]), W'(m_stall[s]));
`else
    chk("stall_cnt_tied", W'(bus.stall_cnt), W'(0));
`endif
    if (bus.c1Tx.wrValid || bus.c1Tx.intrValid) dut_emit[int'(bus.c1Tx.hdr.address[31:28])]++;
    for (int s = 0; s < NS; s++) stim[s] = '0;
  endtask

  task automatic clear_emit();
    for (int s = 0; s < NS; s++) dut_emit[s] = 0;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) stim[s] = '0;
    clear_emit();
    //          rst  req      blk  vld  src alm
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 0, 4'b1111};
    tbl[1]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 0, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2, 4'b0000};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 0, 4'b0000};
    tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 0, 4'b1111};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 0, 4'b0000};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2, 4'b0000};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 3, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 0, 4'b0000};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 0, 4'b0000};

    for (int r = 0; r < 11; r++) begin
      for (int s = 0; s < NS; s++) if (tbl[r].req[s]) stim[s] = mk_req(s, 100 + r, 1'b0);
      cycle(tbl[r].blk, tbl[r].rst);
      chk("tbl_wrValid", W'(bus.c1Tx.wrValid), W'(tbl[r].exp_vld));
      if (tbl[r].exp_vld) chk("tbl_src", W'(bus.c1Tx.hdr.address[31:28]), W'(tbl[r].exp_src));
      chk("tbl_almfull", W'(bus.src_c1TxAlmFull), W'(tbl[r].exp_alm));
    end

    // downstream blocked for 10 cycles while src0 pushes 6, then drain
    cycle(1'b0, 1'b1);
    clear_emit();
    for (int c = 0; c < 10; c++) begin
      if (c < 6) stim[0] = mk_req(0, c, (c % 3) == 0);
      cycle(1'b1, 1'b0);
      if (c == 5) chk("almfull_at_6", W'(bus.src_c1TxAlmFull[0]), W'(1));
    end
    chk("blocked_no_emit", W'(dut_emit[0]), W'(0));
    for (int c = 0; c < 10; c++) cycle(1'b0, 1'b0);
    chk("drain_6", W'(dut_emit[0]), W'(6));

    // nine pushes into a blocked src1: eight kept, overflow sticky
    cycle(1'b0, 1'b1);
    clear_emit();
    for (int c = 0; c < 9; c++) begin
      stim[1] = mk_req(1, 200 + c, 1'b0);
      cycle(1'b1, 1'b0);
    end
    chk("ovf1_set", W'(bus.overflow_err[1]), W'(1));
    for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0);
    chk("ovf_emit_8", W'(dut_emit[1]), W'(8));
    chk("ovf1_sticky", W'(bus.overflow_err[1]), W'(1));

    // full src2 with simultaneous enqueue and dequeue
    cycle(1'b0, 1'b1);
    clear_emit();
    for (int c = 0; c < 8; c++) begin
      stim[2] = mk_req(2, 300 + c, 1'b0);
      cycle(1'b1, 1'b0);
    end
    stim[2] = mk_req(2, 308, 1'b0);
    cycle(1'b0, 1'b0);
    chk("full_enq_deq_no_ovf", W'(bus.overflow_err[2]), W'(0));
    for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0);
    chk("full_enq_deq_emit_9", W'(dut_emit[2]), W'(9));

    // src3 held non-empty but blocked for 5 cycles
    cycle(1'b0, 1'b1);
    stim[3] = mk_req(3, 400, 1'b0);
    cycle(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0);
`ifdef CCIS_TX_BUF_STATS_EN
    chk("stall3_is_5", W'(bus.stall_cnt[3]), W'(5));
`endif
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0);

    // reset in the middle of a drain
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < NS; s++) stim[s] = mk_req(s, 500 + c, 1'b0);
      cycle(1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("rst_mid_valid", W'(bus.c1Tx.wrValid | bus.c1Tx.intrValid), W'(0));
    clear_emit();
    for (int c = 0; c < 8; c++) cycle(1'b0, 1'b0);
    chk("rst_mid_flushed", W'(dut_emit[0] + dut_emit[1] + dut_emit[2] + dut_emit[3]), W'(0));

    // random traffic against the model
    cycle(1'b0, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      for (int s = 0; s < NS; s++) begin
        if ($urandom_range(0, 99) < 40 && (!m_alm[s] || $urandom_range(0, 99) < 5)) begin
          stim[s] = mk_req(s, tag, $urandom_range(0, 3) == 0);
          tag++;
        end
      end
      cycle($urandom_range(0, 99) < 25, $urandom_range(0, 999) == 0);
    end
    for (int c = 0; c < 40; c++) cycle(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
